// File: rtl/fast_pkg.sv
// Shared widths and payload types for the FAST message assembler.
package fast_pkg;

  localparam int unsigned BEAT_W  = 64;
  localparam int unsigned MAX_MSG = 10;
  localparam int unsigned RING    = 16;
  localparam int unsigned SUP     = 4;
  localparam int unsigned ID_W    = 21;
  localparam int unsigned FIDX_W  = $clog2(MAX_MSG);
  localparam int unsigned PTR_W   = $clog2(RING);
  localparam int unsigned CNT_W   = $clog2(RING + 1);
  localparam int unsigned DROP_W  = 16;

  // One lane's field write from the write-back stage
  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   msg_id;
    logic [FIDX_W-1:0] idx;
    logic [BEAT_W-1:0] data;
    logic              last;
  } field_wr_t;

  // Per-slot bookkeeping kept next to the field storage
  typedef struct packed {
    logic               closed;
    logic [ID_W-1:0]    msg_id;
    logic [MAX_MSG-1:0] mask;
  } slot_meta_t;

endpackage

// File: rtl/message_assembler_if.sv
// Field-write lanes in, completed messages out.
interface message_assembler_if;
  import fast_pkg::*;

  logic [SUP-1:0]                  in_valid;
  logic [SUP-1:0][ID_W-1:0]        in_msg_id;
  logic [SUP-1:0][FIDX_W-1:0]      in_field_idx;
  logic [SUP-1:0][BEAT_W-1:0]      in_field;
  logic [SUP-1:0]                  in_last;
  logic                            in_ready;
  logic                            out_valid;
  logic                            out_ready;
  logic [ID_W-1:0]                 out_msg_id;
  logic [MAX_MSG-1:0][BEAT_W-1:0]  out_fields;
  logic [MAX_MSG-1:0]              out_field_mask;
  logic                            id_err;
  logic [DROP_W-1:0]               drop_cnt;

  modport master (
    output in_valid, in_msg_id, in_field_idx, in_field, in_last, out_ready,
    input  in_ready, out_valid, out_msg_id, out_fields, out_field_mask, id_err, drop_cnt
  );

  modport slave (
    input  in_valid, in_msg_id, in_field_idx, in_field, in_last, out_ready,
    output in_ready, out_valid, out_msg_id, out_fields, out_field_mask, id_err, drop_cnt
  );

endinterface

// File: rtl/msg_slot_ctrl.sv
// Ring pointer, occupancy and drop accounting for the message slot ring.
module msg_slot_ctrl
  import fast_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              any_valid_i,
  input  logic              close_i,
  input  logic              head_closed_i,
  input  logic              out_ready_i,
  output logic [PTR_W-1:0]  wr_ptr_o,
  output logic [PTR_W-1:0]  rd_ptr_o,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic              pop_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  // Two free slots are needed: the open one plus the one a mid-cycle close spills into
  assign in_ready_o  = (count_q <= CNT_W'(RING - 2));
  assign out_valid_o = (count_q != '0) && head_closed_i;
  assign pop_o       = out_valid_o && out_ready_i;
  assign wr_ptr_o    = wr_ptr_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign drop_cnt_o  = drop_q;

  // Next pointers, occupancy and saturating drop counter
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (close_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_o)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({close_i, pop_o})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (any_valid_i && !in_ready_o && (drop_q != {DROP_W{1'b1}})) drop_d = drop_q + DROP_W'(1);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: rtl/message_assembler.sv
// Collects per-lane FAST field writes into a ring of message slots and
// presents completed messages in order.
module message_assembler
  import fast_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  message_assembler_if.slave bus
);

  field_wr_t                      lanes [SUP];
  slot_meta_t                     meta_q [RING];
  slot_meta_t                     meta_d [RING];
  logic [MAX_MSG-1:0][BEAT_W-1:0] fields_mem [RING];
  logic [MAX_MSG-1:0]             we_s [2];
  logic [MAX_MSG-1:0][BEAT_W-1:0] wd_s [2];
  logic                           id_err_q, id_err_d;
  logic                           close_c;
  logic                           any_valid_c;
  logic                           pop;
  logic                           in_ready;
  logic                           out_valid;
  logic [PTR_W-1:0]               wr_ptr, rd_ptr, slot_b;
  logic [DROP_W-1:0]              drop_cnt;

  assign slot_b      = wr_ptr + PTR_W'(1);
  assign any_valid_c = |bus.in_valid;

  msg_slot_ctrl u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .any_valid_i  (any_valid_c),
    .close_i      (close_c),
    .head_closed_i(meta_q[rd_ptr].closed),
    .out_ready_i  (bus.out_ready),
    .wr_ptr_o     (wr_ptr),
    .rd_ptr_o     (rd_ptr),
    .in_ready_o   (in_ready),
    .out_valid_o  (out_valid),
    .pop_o        (pop),
    .drop_cnt_o   (drop_cnt)
  );

  // Unpack interface lanes into field-write records
  always_comb begin
    for (int k = 0; k < SUP; k++) begin
      lanes[k].valid  = bus.in_valid[k];
      lanes[k].msg_id = bus.in_msg_id[k];
      lanes[k].idx    = bus.in_field_idx[k];
      lanes[k].data   = bus.in_field[k];
      lanes[k].last   = bus.in_last[k];
    end
  end

  // Walk lanes in order: writes go to the open slot until in_last, then to the next one
  always_comb begin
    logic              sel;
    logic              started [2];
    logic [ID_W-1:0]   sid [2];
    logic              bad;
    meta_d     = meta_q;
    id_err_d   = id_err_q;
    close_c    = 1'b0;
    sel        = 1'b0;
    bad        = 1'b0;
    we_s[0]    = '0;
    we_s[1]    = '0;
    wd_s[0]    = '0;
    wd_s[1]    = '0;
    started[0] = (meta_q[wr_ptr].mask != '0);
    started[1] = 1'b0;
    sid[0]     = meta_q[wr_ptr].msg_id;
    sid[1]     = '0;
    for (int k = 0; k < SUP; k++) begin
      if (in_ready && lanes[k].valid) begin
        if (started[sel] && (lanes[k].msg_id != sid[sel])) bad = 1'b1;
        if (lanes[k].idx < FIDX_W'(MAX_MSG)) begin
          if (!started[sel]) begin
            sid[sel]     = lanes[k].msg_id;
            started[sel] = 1'b1;
          end
          we_s[sel][lanes[k].idx] = 1'b1;
          wd_s[sel][lanes[k].idx] = lanes[k].data;
        end else begin
          bad = 1'b1;
        end
        if (lanes[k].last) begin
          close_c = 1'b1;
          sel     = 1'b1;
        end
      end
    end
    // Popped slot becomes free; it never coincides with a slot being written
    if (pop) begin
      meta_d[rd_ptr].closed = 1'b0;
      meta_d[rd_ptr].mask   = '0;
    end
    if (in_ready) begin
      meta_d[wr_ptr].msg_id = sid[0];
      meta_d[wr_ptr].mask   = meta_q[wr_ptr].mask | we_s[0];
      if (close_c) meta_d[wr_ptr].closed = 1'b1;
      if (started[1]) meta_d[slot_b].msg_id = sid[1];
      meta_d[slot_b].mask = meta_d[slot_b].mask | we_s[1];
    end
    if (bad) id_err_d = 1'b1;
  end

  // Slot metadata and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RING; s++) meta_q[s] <= '0;
      id_err_q <= 1'b0;
    end else begin
      meta_q   <= meta_d;
      id_err_q <= id_err_d;
    end
  end

  // Field storage is never cleared; the mask says which entries are meaningful
  always_ff @(posedge clk) begin
    for (int f = 0; f < MAX_MSG; f++) begin
      if (we_s[0][f]) fields_mem[wr_ptr][f] <= wd_s[0][f];
      if (we_s[1][f]) fields_mem[slot_b][f] <= wd_s[1][f];
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid;
  assign bus.out_msg_id     = meta_q[rd_ptr].msg_id;
  assign bus.out_field_mask = meta_q[rd_ptr].mask;
  assign bus.out_fields     = fields_mem[rd_ptr];
  assign bus.id_err         = id_err_q;
  assign bus.drop_cnt       = drop_cnt;

endmodule

// File: tb/tb_message_assembler.sv
// Directed bench for message_assembler with an in-order message scoreboard.
module tb_message_assembler;
  import fast_pkg::*;

  typedef struct packed {
    logic [ID_W-1:0]                id;
    logic [MAX_MSG-1:0]             mask;
    logic [MAX_MSG-1:0][BEAT_W-1:0] f;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  message_assembler_if bus();

  message_assembler dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t sb[$];
  exp_t cur;
  logic cur_started;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.in_valid     = '0;
    bus.in_msg_id    = '0;
    bus.in_field_idx = '0;
    bus.in_field     = '0;
    bus.in_last      = '0;
  endtask

  task automatic model_reset();
    sb.delete();
    cur         = '0;
    cur_started = 1'b0;
  endtask

  // Drive one lane and fold the write into the message being built
  task automatic wr(input int k, input logic [ID_W-1:0] id, input logic [FIDX_W-1:0] idx,
                    input logic [BEAT_W-1:0] d, input logic last);
    bus.in_valid[k]     = 1'b1;
    bus.in_msg_id[k]    = id;
    bus.in_field_idx[k] = idx;
    bus.in_field[k]     = d;
    bus.in_last[k]      = last;
    if (int'(idx) < MAX_MSG) begin
      if (!cur_started) begin
        cur.id      = id;
        cur_started = 1'b1;
      end
      cur.mask[int'(idx)] = 1'b1;
      cur.f[int'(idx)]    = d;
    end
    if (last) begin
      sb.push_back(cur);
      cur         = '0;
      cur_started = 1'b0;
    end
  endtask

  // Check the head if it is being taken, then advance one clock
  task automatic tick();
    exp_t e;
    checks++;
    assert ($countones(bus.in_valid & bus.in_last) <= 1) else begin
      failures++;
      $error("FAIL one_last observed=%0d expected<=1", $countones(bus.in_valid & bus.in_last));
    end
    if (bus.out_valid && bus.out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_msg observed_id=%0h expected=none", bus.out_msg_id);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("head_id", 64'(bus.out_msg_id), 64'(e.id));
        chk("head_mask", 64'(bus.out_field_mask), 64'(e.mask));
        for (int f = 0; f < MAX_MSG; f++)
          if (e.mask[f]) chk("head_field", bus.out_fields[f], e.f[f]);
      end
    end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_msg_id", 64'(bus.out_msg_id), 64'd0);
    chk("rst_mask", 64'(bus.out_field_mask), 64'd0);
    chk("rst_id_err", 64'(bus.id_err), 64'd0);
    chk("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single 3-field message, visible one cycle after close
    bus.out_ready = 1'b1;
    wr(0, 21'h0001A, 4'd0, 64'h1111_0000_0000_0001, 1'b0);
    wr(1, 21'h0001A, 4'd1, 64'h1111_0000_0000_0002, 1'b0);
    wr(2, 21'h0001A, 4'd2, 64'h1111_0000_0000_0003, 1'b1);
    tick();
    chk("latency_out_valid", 64'(bus.out_valid), 64'd1);
    drain();

    // Two messages sharing a cycle; B completes a cycle later
    wr(0, 21'h00AAA, 4'd0, 64'hA0, 1'b0);
    wr(1, 21'h00AAA, 4'd1, 64'hA1, 1'b1);
    wr(2, 21'h00BBB, 4'd0, 64'hB0, 1'b0);
    wr(3, 21'h00BBB, 4'd1, 64'hB1, 1'b0);
    tick();
    wr(0, 21'h00BBB, 4'd2, 64'hB2, 1'b1);
    tick();
    drain();

    // Same-cycle duplicate index and ID mismatch
    wr(0, 21'h00C0C, 4'd0, 64'hC000, 1'b0);
    wr(1, 21'h00C0C, 4'd4, 64'hC0DE_0001, 1'b0);
    wr(2, 21'h00BAD, 4'd5, 64'hC005, 1'b0);
    wr(3, 21'h00C0C, 4'd4, 64'hC0DE_0003, 1'b1);
    tick();
    chk("id_err_set", 64'(bus.id_err), 64'd1);
    // Later cycle overwrites an earlier one
    wr(0, 21'h00D0D, 4'd3, 64'hD001, 1'b0);
    tick();
    wr(0, 21'h00D0D, 4'd3, 64'hD002, 1'b1);
    tick();
    drain();
    chk("id_err_sticky", 64'(bus.id_err), 64'd1);

    // Fill the ring with out_ready low
    bus.out_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      wr(0, ID_W'(100 + i), 4'd0, 64'hA000 + 64'(i), 1'b1);
      tick();
    end
    chk("count14_in_ready", 64'(bus.in_ready), 64'd1);
    wr(0, ID_W'(114), 4'd0, 64'hA00E, 1'b1);
    tick();
    chk("count15_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_out_valid", 64'(bus.out_valid), 64'd1);
    // Dropped cycle: not fed to the model
    bus.in_valid[0] = 1'b1;
    bus.in_msg_id[0] = 21'h1FFFF;
    bus.in_last[0] = 1'b1;
    tick();
    chk("drop_cnt_one", 64'(bus.drop_cnt), 64'd1);
    chk("drop_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("pop_in_ready", 64'(bus.in_ready), 64'd1);
    // Close and pop together keep occupancy at 14
    wr(0, ID_W'(200), 4'd1, 64'hBEEF_0200, 1'b1);
    tick();
    chk("close_pop_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b0;
    wr(0, ID_W'(201), 4'd2, 64'hBEEF_0201, 1'b1);
    tick();
    chk("close_pop_count15", 64'(bus.in_ready), 64'd0);
    drain();

    // Async reset mid-message with queued messages
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr(0, ID_W'(300 + i), 4'd0, 64'hE000 + 64'(i), 1'b1);
      tick();
    end
    wr(0, ID_W'(399), 4'd0, 64'hE0FF, 1'b0);
    tick();
    chk("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    bus.in_valid[0] = 1'b1;
    bus.in_msg_id[0] = ID_W'(399);
    bus.in_field_idx[0] = 4'd1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("async_rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
    chk("async_rst_id_err", 64'(bus.id_err), 64'd0);
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

    // Out-of-range index is discarded and flagged
    bus.out_ready = 1'b1;
    wr(0, 21'h00E0E, 4'd2, 64'hE2, 1'b0);
    wr(1, 21'h00E0E, 4'd12, 64'hEC, 1'b1);
    tick();
    chk("bad_idx_id_err", 64'(bus.id_err), 64'd1);
    chk("bad_idx_out_valid", 64'(bus.out_valid), 64'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
